led_mode_sched: RTL and testbench
=================================

LED_MODE_SCHED -- requirements
Module: led_mode_sched

Interface
REQ-001 The block SHALL have parameter DIV, default 10000000, giving CLOCK_50 cycles per step (5 Hz at 50 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter DWELL, default 20, giving the number of steps per mode in auto mode; legal range is 1 or more.
REQ-003 The block SHALL have parameter DEB, default 1000000, giving the number of stable cycles needed to accept a new key level; legal range is 1 or more.
REQ-004 Port CLOCK_50: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 Port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-006 Port en: input, 1 bit, synchronous enable; 0 forces the idle condition.
REQ-007 Port auto: input, 1 bit; 1 selects automatic mode cycling.
REQ-008 Port key_n: input, 1 bit, raw asynchronous pushbutton, low when pressed.
REQ-009 Port mode: output, 2 bits, current pattern mode; 0 means off, 1-3 select patterns.
REQ-010 Port load: output, 1 bit; a one-cycle pulse tells the LED shifter to load the seed for mode.
REQ-011 Port step: output, 1 bit; a one-cycle pulse tells the LED shifter to rotate once.

Function
REQ-012 key_n SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The debounced key level SHALL take the synchronized level only after that level has differed from the debounced level for DEB consecutive cycles; any return to the debounced level within that window SHALL restart the count.
REQ-014 A press event SHALL be a one-cycle internal pulse on a debounced 1->0 transition; a release SHALL generate no event.
REQ-015 The tick counter SHALL run 0..DIV-1 while en=1, pulse tick when at DIV-1, and wrap to 0.
REQ-016 The output step SHALL equal tick AND (state==RUN); a tick in any other state SHALL be dropped and not deferred.
REQ-017 The FSM SHALL have three states, IDLE (mode=0), LOAD and RUN.
REQ-018 An advance SHALL set mode to (mode+1) mod 4, or to 1 when auto=1 and mode is 3; it SHALL then enter LOAD for exactly one cycle with load=1.
REQ-019 From LOAD the FSM SHALL go to RUN if mode is nonzero, otherwise to IDLE.
REQ-020 A press event SHALL request an advance in IDLE and in RUN; a press event during LOAD SHALL be ignored.
REQ-021 In RUN with auto=1, the dwell counter SHALL increment on each step and request an advance when a step occurs at count DWELL-1.
REQ-022 In IDLE with auto=1, the next tick SHALL request an advance, so mode goes to 1.
REQ-023 A press event and a dwell expiry in the same cycle SHALL produce exactly one advance.
REQ-024 The dwell counter SHALL clear on every advance, whenever auto=0, and whenever the state is not RUN.
REQ-025 When en=0 the block SHALL, synchronously, set mode=0 and state=IDLE, clear the tick and dwell counters, drive load=0 and step=0, and discard press events; the debounce logic SHALL keep running.
REQ-026 Toggling auto SHALL NOT change mode by itself.

Reset
REQ-027 While reset_n=0 the block SHALL hold mode=0, load=0, step=0, state=IDLE, all counters at 0, and the synchronizer flops and debounced level at 1 (released).
REQ-028 Deassertion of reset_n SHALL take effect on the next CLOCK_50 edge, and a reset mid-LOAD SHALL leave no pending load.

Verification (DIV=4, DWELL=3, DEB=2)
REQ-029 The bench SHALL cover: en=1, auto=0, key_n held low for 4 cycles -> exactly one load pulse, mode=1, then step every 4 cycles.
REQ-030 The bench SHALL cover: key_n low for 1 cycle (glitch) -> no press event and mode unchanged.
REQ-031 The bench SHALL cover: four debounced presses -> mode 1,2,3,0, with a load pulse on each change, and step stopping after mode=0 (IDLE).
REQ-032 The bench SHALL cover: auto=1 from IDLE -> mode 1 at the first tick, then an advance after 3 steps each time, giving the sequence 1,2,3,1; mode 0 is never re-entered.
REQ-033 The bench SHALL cover: auto=1 with a press landing on the dwell-expiry cycle -> a single advance (2->3, not 2->0) and the dwell count restarting at 0.
REQ-034 The bench SHALL cover: en dropped in RUN at mode=2, and reset_n pulsed low during LOAD -> mode=0, step=0, load=0 on the next edge (en) or immediately (reset), with no spurious load afterwards.

Source files
------------

// File: rtl/led_mode_sched.sv
`default_nettype none
// ============================================================================
// Module   : led_mode_sched
// Purpose  : Debounced-key / auto-dwell mode scheduler driving an LED shifter.
// Revision : 1.0
// ============================================================================
module led_mode_sched #(
    parameter int unsigned DIV   = 10000000,
    parameter int unsigned DWELL = 20,
    parameter int unsigned DEB   = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       en,
    input  logic       auto,
    input  logic       key_n,
    output logic [1:0] mode,
    output logic       load,
    output logic       step
);

    localparam int unsigned c_TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned c_DWELL_W = $clog2(DWELL + 1);
    localparam int unsigned c_DEB_W   = $clog2(DEB + 1);

    localparam logic [c_TICK_W-1:0]  c_TICK_LAST  = c_TICK_W'(DIV - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL - 1);
    localparam logic [c_DEB_W-1:0]   c_DEB_LAST   = c_DEB_W'(DEB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    logic [1:0]           r_sync;
    logic                 r_deb;
    logic [c_DEB_W-1:0]   r_deb_cnt;
    logic                 r_press;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [1:0]           r_mode;
    state_t               r_state;

    logic                 w_tick;
    logic                 w_step;
    logic                 w_adv;
    state_t               w_state_nxt;
    logic [1:0]           w_mode_nxt;
    logic [c_DWELL_W-1:0] w_dwell_nxt;

    // Debounce runs regardless of en so a held key is tracked across disables.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync    <= 2'b11;
            r_deb     <= 1'b1;
            r_deb_cnt <= '0;
            r_press   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], key_n};
            r_press <= 1'b0;
            if (r_sync[1] == r_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == c_DEB_LAST) begin
                r_deb     <= r_sync[1];
                r_deb_cnt <= '0;
                r_press   <= ~r_sync[1];
            end else begin
                r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
            end
        end
    end

    assign w_tick = en && (r_tick_cnt == c_TICK_LAST);
    assign w_step = w_tick && (r_state == S_RUN);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (!en || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_mode  <= 2'd0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_dwell_nxt = '0;
        w_adv       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_adv = r_press || (auto && w_tick);
            end
            S_RUN: begin
                w_adv = r_press || (auto && w_step && (r_dwell == c_DWELL_LAST));
                if (auto) begin
                    w_dwell_nxt = w_step ? (r_dwell + c_DWELL_W'(1)) : r_dwell;
                end
            end
            S_LOAD: begin
                w_state_nxt = (r_mode != 2'd0) ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // In auto mode the off pattern is skipped when wrapping past mode 3.
        if (w_adv) begin
            w_mode_nxt  = (auto && (r_mode == 2'd3)) ? 2'd1 : (r_mode + 2'd1);
            w_state_nxt = S_LOAD;
            w_dwell_nxt = '0;
        end

        if (!en) begin
            w_state_nxt = S_IDLE;
            w_mode_nxt  = 2'd0;
            w_dwell_nxt = '0;
        end
    end

    assign mode = r_mode;
    assign load = en && (r_state == S_LOAD);
    assign step = w_step;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_mode_sched
// Purpose  : Self-checking bench for led_mode_sched (DIV=4, DWELL=3, DEB=2).
// Revision : 1.0
// ============================================================================
module tb_led_mode_sched;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DWELL = 3;
    localparam int unsigned DEB   = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_i  = 1'b1;
    logic       auto_i = 1'b0;
    logic       key_i = 1'b1;
    logic [1:0] mode_o;
    logic       load_o;
    logic       step_o;

    int checks = 0;
    int errors = 0;

    led_mode_sched #(.DIV(DIV), .DWELL(DWELL), .DEB(DEB)) dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .en       (en_i),
        .auto     (auto_i),
        .key_n    (key_i),
        .mode     (mode_o),
        .load     (load_o),
        .step     (step_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model: key history, stable-run length, cycles since enable,
    // current mode, phase (0 off/idle, 1 loading, 2 running), steps in mode.
    int m_hist [2];
    int m_deb, m_run, m_press, m_cycles, m_mode, m_phase, m_dwell;

    function automatic void m_reset();
        m_hist[0] = 1;
        m_hist[1] = 1;
        m_deb     = 1;
        m_run     = 0;
        m_press   = 0;
        m_cycles  = 0;
        m_mode    = 0;
        m_phase   = 0;
        m_dwell   = 0;
    endfunction

    function automatic void m_edge(input bit e, input bit a, input bit k);
        int  synced = m_hist[1];
        bit  tick   = e && ((m_cycles % DIV) == DIV - 1);
        bit  stp    = tick && (m_phase == 2);
        bit  adv;
        adv = e && (((m_phase == 0) && (m_press != 0 || (a && tick))) ||
                    ((m_phase == 2) && (m_press != 0 || (a && stp && m_dwell == DWELL - 1))));
        m_press = 0;
        if (synced != m_deb) begin
            m_run++;
            if (m_run >= DEB) begin
                m_deb   = synced;
                m_run   = 0;
                m_press = (synced == 0) ? 1 : 0;
            end
        end else begin
            m_run = 0;
        end
        m_hist[1] = m_hist[0];
        m_hist[0] = k;
        m_cycles  = e ? m_cycles + 1 : 0;
        if (!e) begin
            m_mode = 0; m_phase = 0; m_dwell = 0;
        end else if (adv) begin
            m_mode  = (a && m_mode == 3) ? 1 : (m_mode + 1) % 4;
            m_phase = 1;
            m_dwell = 0;
        end else if (m_phase == 1) begin
            m_phase = (m_mode != 0) ? 2 : 0;
            m_dwell = 0;
        end else if (m_phase == 2) begin
            m_dwell = a ? m_dwell + int'(stp) : 0;
        end else begin
            m_dwell = 0;
        end
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input bit e, input bit a, input bit k);
        logic [3:0] exp_v;
        en_i = e; auto_i = a; key_i = k;
        @(posedge clk);
        m_edge(e, a, k);
        #1;
        exp_v[3:2] = 2'(m_mode);
        exp_v[1]   = e && (m_phase == 1);
        exp_v[0]   = e && ((m_cycles % DIV) == DIV - 1) && (m_phase == 2);
        check("cycle{mode,load,step}", int'({mode_o, load_o, step_o}), int'(exp_v));
    endtask

    task automatic press(input bit a, output int loads);
        loads = 0;
        repeat (4) begin cyc(1'b1, a, 1'b0); loads += int'(load_o); end
        repeat (8) begin cyc(1'b1, a, 1'b1); loads += int'(load_o); end
    endtask

    typedef struct {
        bit en; bit au; bit key; int mode; bit load; bit step;
    } vec_t;

    // Key held low for 4 cycles from reset, auto off.
    vec_t tbl [15] = '{
        '{1,0,0, 0,0,0}, '{1,0,0, 0,0,0}, '{1,0,0, 0,0,0}, '{1,0,0, 0,0,0},
        '{1,0,1, 1,1,0}, '{1,0,1, 1,0,0}, '{1,0,1, 1,0,1}, '{1,0,1, 1,0,0},
        '{1,0,1, 1,0,0}, '{1,0,1, 1,0,0}, '{1,0,1, 1,0,1}, '{1,0,1, 1,0,0},
        '{1,0,1, 1,0,0}, '{1,0,1, 1,0,0}, '{1,0,1, 1,0,1}
    };

    initial begin
        int loads, nsteps, first_lat, zero_seen, found;
        int q_modes[$];
        int q_steps[$];
        bit re, ra, rk;
        int hold;

        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_mode", int'(mode_o), 0);
        check("reset_load", int'(load_o), 0);
        check("reset_step", int'(step_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            en_i = tbl[i].en; auto_i = tbl[i].au; key_i = tbl[i].key;
            @(posedge clk);
            m_edge(tbl[i].en, tbl[i].au, tbl[i].key);
            #1;
            check("tbl_mode", int'(mode_o), tbl[i].mode);
            check("tbl_load", int'(load_o), int'(tbl[i].load));
            check("tbl_step", int'(step_o), int'(tbl[i].step));
        end

        // One-cycle glitch must not advance.
        cyc(1'b1, 1'b0, 1'b0);
        loads = 0;
        repeat (8) begin cyc(1'b1, 1'b0, 1'b1); loads += int'(load_o); end
        check("glitch_mode", int'(mode_o), 1);
        check("glitch_loads", loads, 0);

        // Four presses from off: 1,2,3,0.
        cyc(1'b0, 1'b0, 1'b1);
        check("endrop_mode", int'(mode_o), 0);
        for (int p = 0; p < 4; p++) begin
            press(1'b0, loads);
            check("press_loads", loads, 1);
            check("press_mode", int'(mode_o), (p + 1) % 4);
        end
        nsteps = 0;
        repeat (12) begin cyc(1'b1, 1'b0, 1'b1); nsteps += int'(step_o); end
        check("idle_steps", nsteps, 0);

        // Auto cycling from idle.
        nsteps = 0; first_lat = -1; zero_seen = 0;
        for (int i = 0; i < 80 && q_modes.size() < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (step_o) nsteps++;
            if (q_modes.size() > 0 && mode_o == 2'd0) zero_seen = 1;
            if (load_o) begin
                if (first_lat < 0) first_lat = i;
                q_modes.push_back(int'(mode_o));
                q_steps.push_back(nsteps);
                nsteps = 0;
            end
        end
        check("auto_loads", q_modes.size(), 4);
        check("auto_first_lat_ok", int'(first_lat >= 0 && first_lat <= DIV), 1);
        check("auto_zero_seen", zero_seen, 0);
        if (q_modes.size() == 4) begin
            check("auto_mode0", q_modes[0], 1);
            check("auto_mode1", q_modes[1], 2);
            check("auto_mode2", q_modes[2], 3);
            check("auto_mode3", q_modes[3], 1);
            for (int j = 1; j < 4; j++) check("auto_dwell_steps", q_steps[j], DWELL);
        end

        // Press landing exactly on a dwell-expiry step at mode 2.
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (m_mode == 2 && m_phase == 2 && m_dwell == 1 && (m_cycles % DIV) == DIV - 1)
                found = 1;
        end
        check("coinc_setup_found", found, 1);
        repeat (4) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        check("coinc_mode", int'(mode_o), 3);
        check("coinc_load", int'(load_o), 1);
        nsteps = 0; found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            cyc(1'b1, 1'b1, 1'b1);
            if (load_o) found = 1;
            else nsteps += int'(step_o);
        end
        check("coinc_next_load", found, 1);
        check("coinc_restart_steps", nsteps, DWELL);
        check("coinc_next_mode", int'(mode_o), 1);

        // en dropped while running at mode 2.
        found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            press(1'b0, loads);
            if (m_mode == 2 && m_phase == 2) found = 1;
        end
        check("endis_setup_found", found, 1);
        cyc(1'b0, 1'b0, 1'b1);
        check("endis_mode", int'(mode_o), 0);
        check("endis_load", int'(load_o), 0);
        check("endis_step", int'(step_o), 0);
        loads = 0;
        repeat (12) begin cyc(1'b1, 1'b0, 1'b1); loads += int'(load_o); end
        check("endis_no_load", loads, 0);

        // Asynchronous reset asserted during LOAD.
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cyc(1'b1, 1'b0, (i < 4) ? 1'b0 : 1'b1);
            if (m_phase == 1) found = 1;
        end
        check("rstload_setup_found", found, 1);
        check("rstload_pre_load", int'(load_o), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstload_mode", int'(mode_o), 0);
        check("rstload_load", int'(load_o), 0);
        check("rstload_step", int'(step_o), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        loads = 0;
        repeat (12) begin cyc(1'b1, 1'b0, 1'b1); loads += int'(load_o); end
        check("rstload_no_load", loads, 0);

        // Randomized traffic against the model.
        re = 1'b1; ra = 1'b0; rk = 1'b1; hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                rk   = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 6));
            end
            hold--;
            if ($urandom_range(0, 63) == 0) ra = ~ra;
            re = ($urandom_range(0, 49) != 0);
            cyc(re, ra, rk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
